// File: rtl/pool_stream_if.sv
// Sample-in / result-out bundle between the PE-array stream and the pooling stage.
// The pooling stage uses the slave modport and the stream source uses the master modport.
interface pool_stream_if #(
    parameter int DW  = 8,
    parameter int CHW = 1
);
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic [1:0]           mode;
    logic                 clear;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic [CHW-1:0]       out_ch;
    logic                 busy;

    modport master (
        output in_valid, in_data, mode, clear,
        input  out_valid, out_data, out_ch, busy
    );

    modport slave (
        input  in_valid, in_data, mode, clear,
        output out_valid, out_data, out_ch, busy
    );
endinterface

// File: rtl/pool_stream_unit.sv
// Streaming pooling stage: reduces WIN samples per interleaved channel to one max,
// floor-average or bypass result, one cycle after the sample that closes the window.
module pool_stream_unit #(
    parameter int DW  = 8,
    parameter int WIN = 4,
    parameter int CH  = 1
) (
    input  logic         clk,
    input  logic         reset,
    pool_stream_if.slave s_if
);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam int LW  = $clog2(WIN);
    localparam int AW  = DW + LW;
    localparam logic [LW-1:0]  ELEM_LAST = LW'(WIN - 1);
    localparam logic [CHW-1:0] CH_LAST   = CHW'(CH - 1);

    typedef logic signed [AW-1:0] acc_t;

    acc_t                 acc_q [CH];
    acc_t                 acc_d [CH];
    logic [CHW-1:0]       ch_cnt_q, ch_cnt_d;
    logic [LW-1:0]        elem_cnt_q, elem_cnt_d;
    logic [1:0]           mode_q;
    logic                 out_valid_q, out_valid_d;
    logic signed [DW-1:0] out_data_q, out_data_d;
    logic [CHW-1:0]       out_ch_q, out_ch_d;

    logic                 is_max, is_pool, flush;
    logic [CHW-1:0]       cur_ch;
    logic [LW-1:0]        cur_elem;
    acc_t                 init_val, sample, cur_acc, new_acc;

    assign is_max  = (s_if.mode == 2'd1);
    assign is_pool = (s_if.mode == 2'd1) || (s_if.mode == 2'd2);
    assign flush   = s_if.clear || (s_if.mode != mode_q);
    assign sample  = {{LW{s_if.in_data[DW-1]}}, s_if.in_data};

    // Max windows start from the most negative value, sums start from zero.
    assign init_val = is_max ? {{(LW + 1){1'b1}}, {(DW - 1){1'b0}}} : '0;

    always_comb begin
        acc_d       = acc_q;
        ch_cnt_d    = ch_cnt_q;
        elem_cnt_d  = elem_cnt_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        cur_ch      = flush ? '0 : ch_cnt_q;
        cur_elem    = flush ? '0 : elem_cnt_q;
        cur_acc     = '0;
        new_acc     = '0;

        if (flush) begin
            for (int i = 0; i < CH; i++) acc_d[i] = init_val;
            ch_cnt_d   = '0;
            elem_cnt_d = '0;
        end

        // The flushed view above lets a sample in a mode-change cycle start a fresh window.
        if (!s_if.clear) begin
            if (!is_pool) begin
                out_valid_d = s_if.in_valid;
                out_ch_d    = '0;
                if (s_if.in_valid) out_data_d = s_if.in_data;
            end else if (s_if.in_valid) begin
                cur_acc = acc_d[cur_ch];
                if (is_max) new_acc = (sample > cur_acc) ? sample : cur_acc;
                else        new_acc = cur_acc + sample;

                if (cur_elem == ELEM_LAST) begin
                    acc_d[cur_ch] = init_val;
                    out_valid_d   = 1'b1;
                    out_ch_d      = cur_ch;
                    out_data_d    = is_max ? new_acc[DW-1:0] : DW'(new_acc >>> LW);
                end else begin
                    acc_d[cur_ch] = new_acc;
                end

                if (cur_ch == CH_LAST) begin
                    ch_cnt_d   = '0;
                    elem_cnt_d = (cur_elem == ELEM_LAST) ? '0 : cur_elem + 1'b1;
                end else begin
                    ch_cnt_d   = cur_ch + 1'b1;
                    elem_cnt_d = cur_elem;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < CH; i++) acc_q[i] <= init_val;
            ch_cnt_q    <= '0;
            elem_cnt_q  <= '0;
            mode_q      <= s_if.mode;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            acc_q       <= acc_d;
            ch_cnt_q    <= ch_cnt_d;
            elem_cnt_q  <= elem_cnt_d;
            mode_q      <= s_if.mode;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign s_if.out_valid = out_valid_q;
    assign s_if.out_data  = out_data_q;
    assign s_if.out_ch    = out_ch_q;
    assign s_if.busy      = (ch_cnt_q != '0) || (elem_cnt_q != '0);
endmodule
